fpnew_noncomp_writeback: RTL



---
 rtl/fpnew_pkg.sv | 47 ++++
 rtl/fpnew_skid_buffer.sv | 72 +++++++
 rtl/fpnew_noncomp_writeback.sv | 115 +++++++++++
 3 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPnew types: formats, status flags and classification masks.
// CLASS_MASK_BITS lets downstream blocks size containers for a class result.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef enum logic [9:0] {
        NEGINF     = 10'b00_0000_0001,
        NEGNORM    = 10'b00_0000_0010,
        NEGSUBNORM = 10'b00_0000_0100,
        NEGZERO    = 10'b00_0000_1000,
        POSZERO    = 10'b00_0001_0000,
        POSSUBNORM = 10'b00_0010_0000,
        POSNORM    = 10'b00_0100_0000,
        POSINF     = 10'b00_1000_0000,
        SNAN       = 10'b01_0000_0000,
        QNAN       = 10'b10_0000_0000
    } classmask_e;

    localparam int unsigned CLASS_MASK_BITS = $bits(classmask_e);

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 32;
        endcase
    endfunction

endpackage

// File: rtl/fpnew_skid_buffer.sv
// Two-entry OUT/SKID valid/ready buffer, type-parametric payload.
// in_ready_o depends only on the SKID valid register, so there is no ready path through.
module fpnew_skid_buffer #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic out_valid_reg, out_valid_next;
    logic skid_valid_reg, skid_valid_next;
    T     out_data_reg, out_data_next;
    T     skid_data_reg, skid_data_next;

    logic accept;
    logic out_free;

    assign in_ready_o  = ~skid_valid_reg;
    assign out_valid_o = out_valid_reg;
    assign out_data_o  = out_data_reg;

    assign accept   = in_valid_i & ~skid_valid_reg;
    assign out_free = ~out_valid_reg | out_ready_i;

    always_comb begin
        out_valid_next  = out_valid_reg;
        skid_valid_next = skid_valid_reg;
        out_data_next   = out_data_reg;
        skid_data_next  = skid_data_reg;
        if (flush_i) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (out_free) begin
            // SKID always holds the older entry, so it drains before any new input.
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_data_next   = skid_data_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                out_valid_next = 1'b1;
                out_data_next  = in_data_i;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            out_data_reg   <= '0;
            skid_data_reg  <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            out_data_reg   <= out_data_next;
            skid_data_reg  <= skid_data_next;
        end
    end

endmodule

// File: rtl/fpnew_noncomp_writeback.sv
// Writeback formatter for the non-computational FP lane: NaN-box / extend, 2-entry skid, fflags.
// Sticky fflags exist only when FPNEW_NONCOMP_WB_STICKY_FLAGS_EN is defined.
module fpnew_noncomp_writeback
    import fpnew_pkg::*;
#(
    parameter fp_format_e  FpFormat = fp_format_e'(0),
    parameter int unsigned XLEN     = 64,
    parameter int unsigned TagWidth = 4,
    localparam int unsigned WIDTH   = fp_width(FpFormat)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [WIDTH-1:0]    result_i,
    input  status_t             status_i,
    input  logic                extension_bit_i,
    input  classmask_e          class_mask_i,
    input  logic                is_class_i,
    input  logic                mask_i,
    input  logic [TagWidth-1:0] tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     wdata_o,
    output status_t             wstatus_o,
    output logic                wmask_o,
    output logic [TagWidth-1:0] tag_o,
    input  logic                flush_i,
    input  logic                fflags_clr_i,
    output status_t             fflags_o
);

    typedef struct packed {
        logic [XLEN-1:0]     wdata;
        status_t             status;
        logic                mask;
        logic [TagWidth-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] fp_word;
    logic [XLEN-1:0] class_word;
    entry_t          in_entry;
    entry_t          out_entry;
    logic            out_hs;

    // Per-bit formatting also covers XLEN == WIDTH without a zero-width fill.
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_fmt
        if (gi < WIDTH) begin : g_res
            assign fp_word[gi] = result_i[gi];
        end else begin : g_ext
            assign fp_word[gi] = extension_bit_i;
        end
        if (gi < CLASS_MASK_BITS) begin : g_cls
            assign class_word[gi] = class_mask_i[gi];
        end else begin : g_zero
            assign class_word[gi] = 1'b0;
        end
    end

    always_comb begin
        in_entry.wdata  = is_class_i ? class_word : fp_word;
        in_entry.status = mask_i ? status_i : '0;
        in_entry.mask   = mask_i;
        in_entry.tag    = tag_i;
    end

    fpnew_skid_buffer #(
        .T(entry_t)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_entry),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_entry)
    );

    assign wdata_o   = out_entry.wdata;
    assign wstatus_o = out_entry.status;
    assign wmask_o   = out_entry.mask;
    assign tag_o     = out_entry.tag;
    assign out_hs    = out_valid_o & out_ready_i;

`ifdef FPNEW_NONCOMP_WB_STICKY_FLAGS_EN
    status_t fflags_reg, fflags_next;

    // A clear alongside a handshake wipes only the history, not the retiring flags.
    always_comb begin
        fflags_next = fflags_reg;
        if (out_hs) begin
            fflags_next = fflags_clr_i ? wstatus_o : status_t'(fflags_reg | wstatus_o);
        end else if (fflags_clr_i) begin
            fflags_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_reg <= '0;
        end else begin
            fflags_reg <= fflags_next;
        end
    end

    assign fflags_o = fflags_reg;
`else
    logic unused_fflags;
    assign unused_fflags = fflags_clr_i ^ out_hs;
    assign fflags_o      = '0;
`endif

endmodule
